// File: rtl/wb_slave_mux_pkg.sv
// wb_slave_mux_pkg: shared types and constants for the user-area Wishbone fabric.
package wb_slave_mux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_CSR  = 3'd2,
    ST_ERR  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic [1:0] CSR_STATUS   = 2'd0;
  localparam logic [1:0] CSR_IRQ_MASK = 2'd1;
  localparam logic [1:0] CSR_IRQ_PEND = 2'd2;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_slave_mux_csr.sv
// wb_slave_mux_csr: fault STATUS counters, IRQ mask/pending and the user IRQ outputs.
module wb_slave_mux_csr
  import wb_slave_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wr_en_i,
  input  logic [1:0]            off_i,
  input  logic [NUM_SLAVES-1:0] mask_wdat_i,
  input  logic                  err_evt_i,
  input  logic                  to_evt_i,
  input  logic [7:0]            fault_idx_i,
  input  logic [NUM_SLAVES-1:0] irq_i,
  output logic [31:0]           rdat_o,
  output logic [2:0]            user_irq_o
);

  logic [7:0]            err_cnt_q;
  logic [7:0]            to_cnt_q;
  logic [7:0]            last_idx_q;
  logic                  sticky_q;
  logic [NUM_SLAVES-1:0] mask_q;
  logic                  irq_q;

  // Fault bookkeeping, mask register and registered IRQ summary.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      err_cnt_q  <= '0;
      to_cnt_q   <= '0;
      last_idx_q <= '0;
      sticky_q   <= 1'b0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_q <= |(irq_i & mask_q);
      if (wr_en_i && off_i == CSR_STATUS) begin
        err_cnt_q  <= '0;
        to_cnt_q   <= '0;
        last_idx_q <= '0;
        sticky_q   <= 1'b0;
      end else if (err_evt_i || to_evt_i) begin
        if (err_evt_i && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        if (to_evt_i && to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
        last_idx_q <= fault_idx_i;
        sticky_q   <= 1'b1;
      end
      if (wr_en_i && off_i == CSR_IRQ_MASK) mask_q <= mask_wdat_i;
    end
  end

  // Read mux over the CSR window.
  always_comb begin
    rdat_o = '0;
    case (off_i)
      CSR_STATUS:   rdat_o = {sticky_q, 7'd0, last_idx_q, to_cnt_q, err_cnt_q};
      CSR_IRQ_MASK: rdat_o = 32'(mask_q);
      CSR_IRQ_PEND: rdat_o = 32'(irq_i & mask_q);
      default:      rdat_o = '0;
    endcase
  end

  assign user_irq_o = {1'b0, sticky_q, irq_q};

endmodule

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: user-area Wishbone fabric, NUM_SLAVES slave windows plus one CSR window.
// Optional ack timeout in FWD is enabled by defining WB_SLAVE_MUX_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for master cyc&stb
// FWD   | request forwarded to selected slave, waiting for its ack
// CSR   | one-cycle access to the built-in CSR window
// ERR   | decode error, fault recorded
// RESP  | one-cycle ack to the master with read data
module wb_slave_mux
  import wb_slave_mux_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          SLOT_BITS      = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [SLOT_BITS-1:0]     s_adr_o,
  output logic [31:0]              s_dat_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_irq_i,
  output logic [2:0]               user_irq_o
);

  localparam int IDX_W  = clog2(NUM_SLAVES + 1);
  localparam int HI_LSB = SLOT_BITS + IDX_W;
  localparam logic [IDX_W-1:0] CSR_IDX = IDX_W'(NUM_SLAVES);

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [SLOT_BITS-1:0]  adr_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdat_q;
  logic [NUM_SLAVES-1:0] s_cyc_q;
  logic [NUM_SLAVES-1:0] s_stb_q;
  logic                  ack_q;
  logic [31:0]           rdat_q;

  logic [IDX_W-1:0]      req_idx;
  logic                  base_hit;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic [31:0]           slave_rdat;
  logic                  sel_ack;
  logic                  to_fire;
  logic                  to_take;
  logic [31:0]           csr_rdat;

  assign req_idx  = wbs_adr_i[HI_LSB-1:SLOT_BITS];
  assign base_hit = (wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  // s_stb_q is one-hot on the selected slot, so it masks out acks from other slots.
  assign sel_ack  = |(s_ack_i & s_stb_q);
  assign to_take  = (state_q == ST_FWD) && wbs_cyc_i && !sel_ack && to_fire;

  // Window one-hot decode and read data of the slot currently strobed.
  always_comb begin
    req_onehot = '0;
    slave_rdat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      req_onehot[i] = (req_idx == IDX_W'(i));
      if (s_stb_q[i]) slave_rdat = s_dat_i[32*i +: 32];
    end
  end

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;

  assign to_fire = (state_q == ST_FWD) && (to_cnt_q == '0);

  // Ack timeout down-counter, reloaded while idle and counting only in FWD.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      to_cnt_q <= TO_LOAD;
    end else if (state_q == ST_FWD && to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - 16'd1;
    end
  end
`else
  // No timeout: FWD waits for the slave forever (a negative timeout is not a valid setting).
  assign to_fire = (TIMEOUT_CYCLES < 0);
`endif

  // Main request/response FSM with registered slave-side and master-side outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      s_cyc_q <= '0;
      s_stb_q <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            idx_q  <= req_idx;
            adr_q  <= wbs_adr_i[SLOT_BITS-1:0];
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            wdat_q <= wbs_dat_i;
            if (!base_hit || req_idx > CSR_IDX) begin
              state_q <= ST_ERR;
            end else if (req_idx == CSR_IDX) begin
              state_q <= ST_CSR;
            end else begin
              state_q <= ST_FWD;
              s_cyc_q <= req_onehot;
              s_stb_q <= req_onehot;
            end
          end
        end
        ST_FWD: begin
          if (!wbs_cyc_i) begin
            s_cyc_q <= '0;
            s_stb_q <= '0;
            state_q <= ST_IDLE;
          end else if (sel_ack) begin
            s_cyc_q <= '0;
            s_stb_q <= '0;
            rdat_q  <= slave_rdat;
            ack_q   <= 1'b1;
            state_q <= ST_RESP;
          end else if (to_take) begin
            s_cyc_q <= '0;
            s_stb_q <= '0;
            rdat_q  <= ERR_DATA;
            ack_q   <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_CSR: begin
          rdat_q  <= csr_rdat;
          ack_q   <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_ERR: begin
          rdat_q  <= ERR_DATA;
          ack_q   <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          rdat_q  <= '0;
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  wb_slave_mux_csr #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_csr (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_n_i  (wb_rst_n_i),
    .wr_en_i     ((state_q == ST_CSR) && we_q),
    .off_i       (adr_q[3:2]),
    .mask_wdat_i (wdat_q[NUM_SLAVES-1:0]),
    .err_evt_i   (state_q == ST_ERR),
    .to_evt_i    (to_take),
    .fault_idx_i (8'(idx_q)),
    .irq_i       (s_irq_i),
    .rdat_o      (csr_rdat),
    .user_irq_o  (user_irq_o)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = wdat_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// tb_wb_slave_mux: directed and randomized checks of wb_slave_mux against an address-map model.
module tb_wb_slave_mux;

  localparam int          NS       = 4;
  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam int          TO_CYC   = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  // 5 windows need a 3-bit index field, so the decoded area spans 8 windows of 64 KiB.
  localparam int          WIN_SPAN = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]      sel = '0;
  logic [31:0]     adr = '0, wdat = '0;
  logic            ack;
  logic [31:0]     rdat;
  logic [NS-1:0]   s_cyc, s_stb;
  logic            s_we;
  logic [3:0]      s_sel;
  logic [15:0]     s_adr;
  logic [31:0]     s_wdat;
  logic [32*NS-1:0] s_rdat = '0;
  logic [NS-1:0]   s_ack = '0, s_irq = '0;
  logic [2:0]      uirq;

  int n_checks = 0;
  int n_fail = 0;

  // reference model of the CSR state
  int m_err = 0, m_to = 0, m_last = 0, m_sticky = 0, m_mask = 0;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE), .SLOT_BITS(16),
    .TIMEOUT_CYCLES(TO_CYC), .ERR_DATA(ERR_DATA)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .s_irq_i(s_irq), .user_irq_o(uirq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return (32'(m_sticky) << 31) | (32'(m_last) << 16) | (32'(m_to) << 8) | 32'(m_err);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_dat"}, rdat, 0);
    chk({tag, "_scyc"}, 32'(s_cyc), 0);
    chk({tag, "_sstb"}, 32'(s_stb), 0);
    chk({tag, "_sadr"}, 32'(s_adr), 0);
    chk({tag, "_swdat"}, s_wdat, 0);
    chk({tag, "_swe_sel"}, {27'd0, s_we, s_sel}, 0);
    chk({tag, "_uirq"}, 32'(uirq), 0);
  endtask

  // One complete master transaction; the bench also plays the selected slave.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] bsel, input int lat);
    int win, kind, off, ack_at, exp_at;
    logic [31:0] exp_dat, got, sdat;
    bit hit;
    hit  = (a >= BASE) && ((a - BASE) < (32'(WIN_SPAN) << 16));
    win  = hit ? int'((a - BASE) >> 16) : -1;
    kind = (hit && win < NS) ? 0 : (hit && win == NS) ? 1 : 2;
    off  = int'((a >> 2) & 32'd3);
    sdat = $urandom;
    case (kind)
      0: exp_dat = sdat;
      1: exp_dat = (off == 0) ? m_status() : (off == 1) ? 32'(m_mask) :
                   (off == 2) ? (32'(s_irq) & 32'(m_mask)) : 32'd0;
      default: exp_dat = ERR_DATA;
    endcase
    exp_at = (kind == 0) ? 2 + lat : 2;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = bsel;
    ack_at = -1;
    got = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("slave_stb", 32'(s_stb), (kind == 0) ? (32'd1 << win) : 32'd0);
        if (kind == 0) begin
          chk("slave_cyc", 32'(s_cyc), 32'd1 << win);
          chk("slave_adr", 32'(s_adr), a & 32'hFFFF);
          chk("slave_we", 32'(s_we), 32'(w));
          if (w) begin
            chk("slave_wdat", s_wdat, d);
            chk("slave_sel", 32'(s_sel), 32'(bsel));
          end
        end
      end
      if (ack) begin
        ack_at = c;
        got = rdat;
        break;
      end
      if (kind == 0) begin
        for (int i = 0; i < NS; i++) s_rdat[32*i +: 32] = $urandom;
        s_ack = NS'($urandom) & ~(NS'(1) << win);
        if (c == 1 + lat) begin
          s_ack[win] = 1'b1;
          s_rdat[32*win +: 32] = sdat;
        end
      end
    end
    chk("ack_latency", ack_at, exp_at);
    if (!w) chk("read_data", got, exp_dat);
    cyc = 0; stb = 0; s_ack = '0;
    if (kind == 2) begin
      if (m_err < 255) m_err++;
      m_last = int'((a >> 16) % WIN_SPAN);
      m_sticky = 1;
    end else if (kind == 1 && w) begin
      if (off == 0) begin m_err = 0; m_to = 0; m_last = 0; m_sticky = 0; end
      if (off == 1) m_mask = int'(d) & ((1 << NS) - 1);
    end
    @(negedge clk);
    chk("ack_single", {31'd0, ack}, 0);
    chk("dat_idle", rdat, 0);
    chk("scyc_idle", 32'(s_cyc), 0);
    chk("user_irq", 32'(uirq), {29'd0, 1'b0, m_sticky[0], |(s_irq & NS'(m_mask))});
  endtask

  initial begin
    int r, w, ackseen;
    logic [31:0] a;
    // reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // directed: write to slot 1, read slot 2, decode error, STATUS clear
    xfer(1, 32'h3001_0010, 32'h1234_5678, 4'hF, 2);
    xfer(0, 32'h3002_0004, 32'h0, 4'h0, 1);
    xfer(0, 32'h3007_0000, 32'h0, 4'h0, 0);
    chk("status_after_err_model", m_status(), 32'h8007_0001);
    xfer(0, 32'h3004_0000, 32'h0, 4'h0, 0);
    xfer(1, 32'h3004_0000, 32'h0, 4'hF, 0);
    xfer(0, 32'h3004_0000, 32'h0, 4'h0, 0);

    // IRQ mask / pending
    s_irq = 4'b0110;
    xfer(1, 32'h3004_0004, 32'h4, 4'hF, 0);
    xfer(0, 32'h3004_0008, 32'h0, 4'h0, 0);
    xfer(0, 32'h3004_0004, 32'h0, 4'h0, 0);
    xfer(1, 32'h3004_0004, 32'h0, 4'hF, 0);
    xfer(0, 32'h3004_0008, 32'h0, 4'h0, 0);

    // randomized traffic over slaves, CSRs and bad addresses
    for (int n = 0; n < 60; n++) begin
      s_irq = NS'($urandom);
      r = $urandom_range(0, 9);
      if (r < 5) begin
        w = $urandom_range(0, NS - 1);
        a = BASE + (32'(w) << 16) + ($urandom & 32'hFFFC);
        xfer(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 4));
      end else if (r < 8) begin
        a = BASE + (32'(NS) << 16) + (32'($urandom_range(0, 3)) << 2) + (($urandom & 32'hFF) << 4);
        xfer(1'($urandom_range(0, 3) == 0), a, $urandom, 4'hF, 0);
      end else begin
        if ($urandom_range(0, 1) == 1)
          a = BASE + (32'($urandom_range(NS + 1, WIN_SPAN - 1)) << 16) + ($urandom & 32'hFFFF);
        else
          a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
        xfer(1'($urandom), a, $urandom, 4'hF, 0);
      end
    end
    xfer(0, 32'h3004_0000, 32'h0, 4'h0, 0);

    // abort: master drops cyc while the slave is still pending
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3002_0100;
    repeat (3) @(negedge clk);
    chk("abort_stb_before", 32'(s_stb), 32'b0100);
    cyc = 0; stb = 0;
    @(negedge clk);
    chk("abort_scyc", 32'(s_cyc), 0);
    chk("abort_sstb", 32'(s_stb), 0);
    ackseen = 0;
    repeat (4) begin @(negedge clk); if (ack) ackseen++; end
    chk("abort_no_ack", ackseen, 0);

    // slot 3 never acks
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3003_0000;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
    ackseen = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (ack) begin ackseen = c; chk("timeout_data", rdat, ERR_DATA); break; end
    end
    chk("timeout_latency", ackseen, TO_CYC + 1);
    cyc = 0; stb = 0;
    if (m_to < 255) m_to++;
    m_last = 3; m_sticky = 1;
    @(negedge clk);
    chk("timeout_scyc", 32'(s_cyc), 0);
    xfer(0, 32'h3004_0000, 32'h0, 4'h0, 0);
`else
    ackseen = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (ack) ackseen++;
    end
    chk("no_timeout_no_ack", ackseen, 0);
    chk("no_timeout_still_fwd", 32'(s_stb), 32'b1000);
    cyc = 0; stb = 0;
    @(negedge clk);
    chk("no_timeout_abort", 32'(s_cyc), 0);
    xfer(0, 32'h3004_0000, 32'h0, 4'h0, 0);
`endif

    // reset in the middle of a forwarded write
    s_irq = 4'b0001;
    xfer(1, 32'h3004_0004, 32'h1, 4'hF, 0);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0040; wdat = 32'hA5A5_5A5A; sel = 4'h3;
    @(negedge clk);
    chk("pre_reset_stb", 32'(s_stb), 32'b0001);
    #2 rst_n = 0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; sel = 0; wdat = 0;
    rst_n = 1;
    m_err = 0; m_to = 0; m_last = 0; m_sticky = 0; m_mask = 0;
    ackseen = 0;
    repeat (4) begin @(negedge clk); if (ack) ackseen++; end
    chk("midreset_no_ack", ackseen, 0);
    xfer(0, 32'h3004_0000, 32'h0, 4'h0, 0);
    xfer(0, 32'h3004_0004, 32'h0, 4'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
Parametrised Wishbone slave fabric for the user area. It replaces the single hard-wired core behind the management Wishbone port with NUM_SLAVES address windows, plus one built-in CSR window for fault status and IRQ masking.
- Registered request/response path, one outstanding transaction.
- Decode-error responses; optional ack timeout.
- Sits between the user_project_wrapper Wishbone pins and the user cores (AES instance in slot 0).

Parameters:
NUM_SLAVES, 4, number of downstream slave windows (1..15)
BASE_ADDR, 32'h3000_0000, user-area Wishbone base address
SLOT_BITS, 16, log2 of window size in bytes (64 KiB windows)
TIMEOUT_CYCLES, 255, cycles in FWD before a timeout fault (used only with the optional feature)
ERR_DATA, 32'hDEAD_BEEF, read data returned on any fault

Ports:
wb_clk_i  in  1  single clock
wb_rst_n_i  in  1  reset, asynchronous assert, active-low
wbs_cyc_i  in  1  master cycle
wbs_stb_i  in  1  master strobe
wbs_we_i  in  1  master write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  one-cycle ack
wbs_dat_o  out  32  read data
s_cyc_o  out  NUM_SLAVES  one-hot slave cycle
s_stb_o  out  NUM_SLAVES  one-hot slave strobe
s_we_o  out  1  shared write enable
s_sel_o  out  4  shared byte selects
s_adr_o  out  SLOT_BITS  offset within window
s_dat_o  out  32  shared write data
s_dat_i  in  32*NUM_SLAVES  packed slave read data, slot i at [32i+31:32i]
s_ack_i  in  NUM_SLAVES  slave acks
s_irq_i  in  NUM_SLAVES  slave level interrupts
user_irq_o  out  3  [0] masked slave IRQ, [1] sticky fault, [2] tied 0

Behaviour:
- Reset: all outputs 0; FSM in IDLE; CSRs 0.
- Decode:
  - IDX_W = clog2(NUM_SLAVES+1); idx = adr[SLOT_BITS+IDX_W-1:SLOT_BITS].
  - Bits above idx must match BASE_ADDR, else decode error.
  - idx<NUM_SLAVES selects a slave; idx==NUM_SLAVES selects the CSR window; larger idx is a decode error.
- FSM states: IDLE, FWD, CSR, ERR, RESP.
  - IDLE: on cyc&stb, latch adr/dat/we/sel/idx; go FWD, CSR or ERR.
  - FWD: s_cyc_o/s_stb_o[idx] high from registers; on s_ack_i[idx], capture s_dat_i slot; go RESP.
  - CSR: one cycle access; go RESP.
  - ERR: load ERR_DATA, err_count+1, sticky=1, last_idx=idx; go RESP.
  - RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o valid; go IDLE. wbs_dat_o returns to 0 otherwise.
- Latency:
  - Slave sees stb 1 cycle after the master.
  - Master ack 1 cycle after the slave ack.
  - CSR/ERR ack 2 cycles after the request.
- Acks on unselected s_ack_i bits are ignored.
- Abort: wbs_cyc_i low while in FWD → slave cyc/stb drop next cycle, IDLE, no ack.
- Reset mid-transaction: outputs clear immediately; no ack is issued.
- Writes: data is forwarded unchanged; s_sel_o passes through; reads ignore sel.
- CSR window (offset bits [3:2]):
  - 0 STATUS: [7:0] err_count (saturating 255), [15:8] to_count (saturating), [23:16] last_idx, [31] sticky. Any write clears the whole register.
  - 1 IRQ_MASK: [NUM_SLAVES-1:0] RW.
  - 2 IRQ_PEND: RO, s_irq_i & mask.
  - 3: reads 0, writes ignored.
- Only one transaction is in flight, so a CSR clear never coincides with a fault increment.
- user_irq_o[0] = registered |(s_irq_i & mask); one-cycle latency.
- user_irq_o[1] = sticky.

Optional Feature:
WB_SLAVE_MUX_TIMEOUT_EN
- Defined: an 8..16-bit counter runs in FWD. When it reaches TIMEOUT_CYCLES, slave cyc/stb drop, wbs_dat_o=ERR_DATA, to_count+1, sticky=1, last_idx=idx, then RESP.
- Undefined: FWD waits indefinitely; to_count stays 0.

Decomposition:
- Package wb_slave_mux_pkg holds:
  - FSM state enum
  - CSR offsets (STATUS=0, IRQ_MASK=1, IRQ_PEND=2)
  - default ERR_DATA
  - clog2 helper
- One sub-module, wb_slave_mux_csr: STATUS counters, mask, pending logic and IRQ outputs.

Test Plan:
1. Write 0x3001_0010 data 0x1234_5678; slot 1 acks 2 cycles after stb → s_cyc_o=4'b0010, s_adr_o=0x0010, s_dat_o=0x1234_5678, wbs_ack_o one cycle, 1 cycle after s_ack_i.
2. Read 0x3002_0004 with slot 2 data 0xCAFE_F00D → wbs_dat_o=0xCAFE_F00D with ack; other slots' acks ignored.
3. Read 0x3007_0000 → ack 2 cycles later, data 0xDEAD_BEEF. STATUS reads 0x8007_0001; user_irq_o[1]=1. Write STATUS → reads 0, irq[1]=0.
4. TIMEOUT_CYCLES=16, macro on: slot 3 never acks → ERR_DATA ack after 16 FWD cycles, STATUS[15:8]=1. Macro off: no ack after 1000 cycles.
5. IRQ_MASK=0x4, s_irq_i=4'b0110 → IRQ_PEND=0x4, user_irq_o[0]=1 one cycle later; mask=0 → 0.
6. Drop wbs_cyc_i in FWD → s_cyc_o=0 next cycle, no ack. Assert wb_rst_n_i low mid-FWD → all outputs 0 immediately.
